// File: rtl/sd_response_receiver.sv
// SD CMD-line response receiver: waits up to TIMEOUT edges for a start bit,
// shifts in a 48-bit response MSB first and checks its CRC7 and framing bits.
module sd_response_receiver #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        iClock_SD,
  input  logic        iReset,
  input  logic        iEnable_STP,
  input  logic        iCmd_in,
  output logic [37:0] oPad_response,
  output logic        oReception_complete,
  output logic        oNo_response,
  output logic        oCrc_error,
  output logic        oFrame_error
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_RECEIVE = 3'd2,
    S_DONE    = 3'd3,
    S_NO_RESP = 3'd4
  } state_t;

  // The TIMEOUT-th idle edge wins over a coincident start bit.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = crc[6] ^ bit_in;
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic [5:0]  bcnt_q, bcnt_d;
  logic [6:0]  crc_q, crc_d;
  logic [46:0] frame_q, frame_d;
  logic [47:0] full_s;
  logic [37:0] pad_q, pad_d;
  logic        done_q, done_d;
  logic        nores_q, nores_d;
  logic        crcerr_q, crcerr_d;
  logic        frmerr_q, frmerr_d;

  // On the last edge the register holds frame bits 47..1 and the pad supplies bit 0.
  assign full_s = {frame_q, iCmd_in};

  assign oPad_response       = pad_q;
  assign oReception_complete = done_q;
  assign oNo_response        = nores_q;
  assign oCrc_error          = crcerr_q;
  assign oFrame_error        = frmerr_q;

  // State register
  always_ff @(posedge iClock_SD or negedge iReset) begin
    if (!iReset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (iEnable_STP) state_d = S_WAIT;
        else             state_d = S_IDLE;
      end
      S_WAIT: begin
        if (!iEnable_STP)             state_d = S_IDLE;
        else if (tcnt_q == TMO_LAST)  state_d = S_NO_RESP;
        else if (!iCmd_in)            state_d = S_RECEIVE;
        else                          state_d = S_WAIT;
      end
      S_RECEIVE: begin
        if (!iEnable_STP)           state_d = S_IDLE;
        else if (bcnt_q == 6'd47)   state_d = S_DONE;
        else                        state_d = S_RECEIVE;
      end
      S_DONE, S_NO_RESP: begin
        if (!iEnable_STP) state_d = S_IDLE;
        else              state_d = state_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values, keyed on the transition taken
  always_comb begin
    tcnt_d   = tcnt_q;
    bcnt_d   = bcnt_q;
    crc_d    = crc_q;
    frame_d  = frame_q;
    pad_d    = pad_q;
    done_d   = done_q;
    nores_d  = nores_q;
    crcerr_d = crcerr_q;
    frmerr_d = frmerr_q;
    case (state_q)
      S_IDLE: begin
        if (state_d == S_WAIT) tcnt_d = 8'd0;
        else                   tcnt_d = tcnt_q;
      end
      S_WAIT: begin
        if (state_d == S_RECEIVE) begin
          frame_d = {46'd0, iCmd_in};
          bcnt_d  = 6'd1;
          crc_d   = crc7_step(7'h00, iCmd_in);
        end else if (state_d == S_NO_RESP) begin
          nores_d = 1'b1;
        end else if (state_d == S_WAIT) begin
          tcnt_d = tcnt_q + 8'd1;
        end else begin
          tcnt_d = tcnt_q;
        end
      end
      S_RECEIVE: begin
        if (state_d == S_RECEIVE) begin
          frame_d = full_s[46:0];
          bcnt_d  = bcnt_q + 6'd1;
          if (bcnt_q < 6'd40) crc_d = crc7_step(crc_q, iCmd_in);
          else                crc_d = crc_q;
        end else if (state_d == S_DONE) begin
          frame_d  = full_s[46:0];
          pad_d    = full_s[45:8];
          done_d   = 1'b1;
          crcerr_d = (crc_q != full_s[7:1]);
          frmerr_d = full_s[46] | ~full_s[0];
        end else begin
          frame_d = frame_q;
        end
      end
      S_DONE, S_NO_RESP: begin
        if (state_d == S_IDLE) begin
          done_d   = 1'b0;
          nores_d  = 1'b0;
          crcerr_d = 1'b0;
          frmerr_d = 1'b0;
        end else begin
          done_d = done_q;
        end
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge iClock_SD or negedge iReset) begin
    if (!iReset) begin
      tcnt_q   <= 8'd0;
      bcnt_q   <= 6'd0;
      crc_q    <= 7'h00;
      frame_q  <= 47'd0;
      pad_q    <= 38'h0;
      done_q   <= 1'b0;
      nores_q  <= 1'b0;
      crcerr_q <= 1'b0;
      frmerr_q <= 1'b0;
    end else begin
      tcnt_q   <= tcnt_d;
      bcnt_q   <= bcnt_d;
      crc_q    <= crc_d;
      frame_q  <= frame_d;
      pad_q    <= pad_d;
      done_q   <= done_d;
      nores_q  <= nores_d;
      crcerr_q <= crcerr_d;
      frmerr_q <= frmerr_d;
    end
  end

endmodule

// File: tb/tb_sd_response_receiver.sv
// Scoreboard bench for sd_response_receiver: stimulus pushes the outcome predicted
// from frame contents and idle length; a negedge monitor pops on each flag rise.
module tb_sd_response_receiver;

  localparam int TMO = 64;
  localparam logic [47:0] R7 = 48'h08_0000_01AA_13;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        cmd;
  logic [37:0] pad;
  logic        rc, nr, ce, fe;

  sd_response_receiver #(.TIMEOUT(TMO)) dut (
    .iClock_SD          (clk),
    .iReset             (rst_n),
    .iEnable_STP        (en),
    .iCmd_in            (cmd),
    .oPad_response      (pad),
    .oReception_complete(rc),
    .oNo_response       (nr),
    .oCrc_error         (ce),
    .oFrame_error       (fe)
  );

  typedef struct {
    bit          is_nores;
    longint      cyc;
    logic [37:0] pad;
    bit          crc_e;
    bit          frm_e;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  longint      cyc = 0;
  logic [37:0] last_pad = 38'h0;
  logic        prev_rc = 1'b0;
  logic        prev_nr = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1
  function automatic logic [6:0] ref_crc7(input logic [39:0] msg);
    logic [46:0] r;
    r = {msg, 7'd0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r = r ^ (47'h89 << (i - 7));
    return r[6:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Called on a negedge with the receiver idle; abort_after < 48 drops the request mid-frame.
  task automatic run_txn(input int n_idle, input logic [47:0] frame, input int abort_after);
    exp_t   e;
    bit     tmo;
    longint c0;
    c0  = cyc;
    tmo = (n_idle >= TMO - 1);
    if (abort_after >= 48) begin
      e.is_nores = tmo;
      e.cyc      = tmo ? c0 + TMO + 1 : c0 + n_idle + 49;
      e.pad      = tmo ? last_pad : frame[45:8];
      e.crc_e    = tmo ? 1'b0 : (ref_crc7(frame[47:8]) != frame[7:1]);
      e.frm_e    = tmo ? 1'b0 : (frame[46] | ~frame[0]);
      sb.push_back(e);
    end
    en  = 1'b1;
    cmd = 1'b1;
    repeat (n_idle + 1) @(negedge clk);
    for (int k = 0; k < 48 && k < abort_after; k++) begin
      cmd = frame[47 - k];
      @(negedge clk);
    end
    if (abort_after < 48) begin
      en  = 1'b0;
      cmd = 1'($urandom);
      @(negedge clk);
      check("abort_flags", {60'd0, rc, nr, ce, fe}, 64'd0);
      check("abort_pad", {26'd0, pad}, {26'd0, last_pad});
    end else begin
      if (!tmo) last_pad = frame[45:8];
      repeat (3) begin
        cmd = 1'($urandom);
        @(negedge clk);
      end
      check("hold_flags", {62'd0, rc, nr}, {62'd0, !tmo, tmo});
      en = 1'b0;
      @(negedge clk);
      check("release_flags", {60'd0, rc, nr, ce, fe}, 64'd0);
      check("release_pad", {26'd0, pad}, {26'd0, last_pad});
    end
    cmd = 1'b1;
    @(negedge clk);
  endtask

  // Monitor: exclusivity every cycle, scoreboard pop on each flag rising edge
  always @(negedge clk) begin
    total++;
    if (rc && nr) begin
      bad++;
      $display("FAIL exclusive: complete=%0b no_response=%0b required not both", rc, nr);
    end
    if ((rc && !prev_rc) || (nr && !prev_nr)) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: complete=%0b no_response=%0b at cycle %0d", rc, nr, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (nr != mon_e.is_nores || rc == mon_e.is_nores || cyc != mon_e.cyc) begin
          bad++;
          $display("FAIL event_kind_time: got nores=%0b at cycle %0d required nores=%0b at cycle %0d",
                   nr, cyc, mon_e.is_nores, mon_e.cyc);
        end
        total++;
        if (pad != mon_e.pad || ce != mon_e.crc_e || fe != mon_e.frm_e) begin
          bad++;
          $display("FAIL event_payload: got pad=%0h crc=%0b frm=%0b required pad=%0h crc=%0b frm=%0b",
                   pad, ce, fe, mon_e.pad, mon_e.crc_e, mon_e.frm_e);
        end
      end
    end
    prev_rc = rc;
    prev_nr = nr;
  end

  initial begin
    logic [39:0] msg;
    logic [6:0]  crc;
    logic        endb;
    rst_n = 1'b0;
    en    = 1'b0;
    cmd   = 1'b1;
    #12;
    check("reset_outputs", {22'd0, pad, rc, nr, ce, fe}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(5, R7, 48);
    run_txn(80, 48'hFFFF_FFFF_FFFF, 48);
    run_txn(5, {R7[47:8], 8'h15}, 48);
    run_txn(5, {R7[47:8], 8'h12}, 48);

    run_txn(3, 48'h05_1234_5678_01, 20);
    repeat (4) begin
      cmd = 1'($urandom);
      @(negedge clk);
    end
    cmd = 1'b1;
    run_txn(2, R7, 48);

    // Asynchronous reset in the middle of a reception
    en  = 1'b1;
    cmd = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      cmd = R7[47 - k];
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {22'd0, pad, rc, nr, ce, fe}, 64'd0);
    last_pad = 38'h0;
    @(negedge clk);
    en    = 1'b0;
    rst_n = 1'b1;
    repeat (40) begin
      cmd = 1'($urandom);
      @(negedge clk);
    end
    check("no_enable_flags", {60'd0, rc, nr, ce, fe}, 64'd0);
    cmd = 1'b1;
    @(negedge clk);
    run_txn(4, R7, 48);

    run_txn(TMO - 1, R7, 48);
    run_txn(TMO - 2, R7, 48);

    for (int t = 0; t < 10; t++) begin
      msg       = {2'b00, 6'($urandom), 32'($urandom)};
      msg[38]   = ($urandom_range(0, 7) == 0);
      crc       = ref_crc7(msg);
      if ($urandom_range(0, 3) == 0) crc = crc ^ 7'(1 << $urandom_range(0, 6));
      endb      = ($urandom_range(0, 7) != 0);
      run_txn($urandom_range(0, 70), {msg, crc, endb}, 48);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
